// File: rtl/tsp_pkg.sv
// Shared definitions for the TSP annealing datapath: city word layout,
// distance width, default sizing and the tour_length state encoding.
package tsp_pkg;

    localparam int unsigned COORD_W         = 32;
    localparam int unsigned CITY_W          = 2 * COORD_W;
    localparam int unsigned DIST_W          = 32;
    localparam int unsigned NCITIES_MAX_DEF = 64;
    localparam int unsigned CIDX_W_DEF      = 6;
    localparam int unsigned SUM_W_DEF       = 32;

    typedef enum logic [2:0] {
        TL_IDLE,
        TL_PRIME,
        TL_STREAM,
        TL_CLOSE,
        TL_DRAIN,
        TL_FIN
    } tl_state_e;

    // City word: Y in the upper half, X in the lower half.
    function automatic logic [CITY_W-1:0] city_pack(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/tour_length.sv
// Walks a tour held in the city RAM, issues one city pair per edge (closing
// edge last) to the distance unit and sums the returned edge lengths.
module tour_length
    import tsp_pkg::*;
#(
    parameter int unsigned NCITIES_MAX = NCITIES_MAX_DEF,
    parameter int unsigned CIDX_W      = CIDX_W_DEF,
    parameter int unsigned SUM_W       = SUM_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CIDX_W:0]     num_cities,
    output logic                city_rd_en,
    output logic [CIDX_W-1:0]   city_addr,
    input  logic [CITY_W-1:0]   city_data,
    output logic [CITY_W-1:0]   dist_citya,
    output logic [CITY_W-1:0]   dist_cityb,
    output logic                dist_valid,
    input  logic                dist_res_valid,
    input  logic [DIST_W-1:0]   dist_res,
    output logic                busy,
    output logic                done,
    output logic [SUM_W-1:0]    total_len
);

    localparam int unsigned CNT_W = CIDX_W + 1;
    localparam logic [CNT_W-1:0] N_MAX = CNT_W'(NCITIES_MAX);

    tl_state_e           state, state_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [CNT_W-1:0]    rcv_q, rcv_d;
    logic [SUM_W-1:0]    acc_q, acc_d;
    logic [CITY_W-1:0]   first_q, first_d;
    logic [CITY_W-1:0]   prev_q, prev_d;
    logic                rd_q;
    logic [CIDX_W-1:0]   rd_addr_q;

    logic                rd_en_d;
    logic [CIDX_W-1:0]   addr_d;
    logic [CITY_W-1:0]   citya_d, cityb_d;
    logic                valid_d;
    logic                busy_d;
    logic                done_d;
    logic [SUM_W-1:0]    total_d;
    logic [CNT_W-1:0]    n_clamp;
    logic [CNT_W-1:0]    last_pos;
    logic                res_hit;

    // State and output registers; rd_q/rd_addr_q track which read the RAM
    // is returning this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= TL_IDLE;
            n_q        <= '0;
            rcv_q      <= '0;
            acc_q      <= '0;
            first_q    <= '0;
            prev_q     <= '0;
            rd_q       <= 1'b0;
            rd_addr_q  <= '0;
            city_rd_en <= 1'b0;
            city_addr  <= '0;
            dist_citya <= '0;
            dist_cityb <= '0;
            dist_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            total_len  <= '0;
        end else begin
            state      <= state_d;
            n_q        <= n_d;
            rcv_q      <= rcv_d;
            acc_q      <= acc_d;
            first_q    <= first_d;
            prev_q     <= prev_d;
            rd_q       <= city_rd_en;
            rd_addr_q  <= city_addr;
            city_rd_en <= rd_en_d;
            city_addr  <= addr_d;
            dist_citya <= citya_d;
            dist_cityb <= cityb_d;
            dist_valid <= valid_d;
            busy       <= busy_d;
            done       <= done_d;
            total_len  <= total_d;
        end
    end

    always_comb begin
        state_d  = state;
        n_d      = n_q;
        rcv_d    = rcv_q;
        acc_d    = acc_q;
        first_d  = first_q;
        prev_d   = prev_q;
        rd_en_d  = 1'b0;
        addr_d   = city_addr;
        citya_d  = dist_citya;
        cityb_d  = dist_cityb;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        total_d  = total_len;
        n_clamp  = (num_cities > N_MAX) ? N_MAX : num_cities;
        last_pos = n_q - CNT_W'(1);
        res_hit  = dist_res_valid && (state inside {TL_PRIME, TL_STREAM, TL_CLOSE, TL_DRAIN});

        if (res_hit) begin
            acc_d = acc_q + SUM_W'(dist_res);
            rcv_d = rcv_q + CNT_W'(1);
        end

        // Returning city data: position 0 seeds the walk, later ones form an edge.
        if (rd_q) begin
            if (rd_addr_q == '0) begin
                first_d = city_data;
                prev_d  = city_data;
            end else begin
                citya_d = prev_q;
                cityb_d = city_data;
                valid_d = 1'b1;
                prev_d  = city_data;
            end
        end

        case (state)
            TL_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    rcv_d   = '0;
                    total_d = '0;
                    if (n_clamp >= CNT_W'(2)) begin
                        n_d     = n_clamp;
                        rd_en_d = 1'b1;
                        addr_d  = '0;
                        state_d = TL_PRIME;
                    end else begin
                        // Degenerate tour: nothing to fetch, zero results to wait for.
                        n_d     = '0;
                        state_d = TL_DRAIN;
                    end
                end
            end
            TL_PRIME: begin
                rd_en_d = 1'b1;
                addr_d  = CIDX_W'(1);
                state_d = TL_STREAM;
            end
            TL_STREAM: begin
                if (city_rd_en && (CNT_W'(city_addr) != last_pos)) begin
                    rd_en_d = 1'b1;
                    addr_d  = city_addr + CIDX_W'(1);
                end
                if (rd_q && (CNT_W'(rd_addr_q) == last_pos)) begin
                    state_d = TL_CLOSE;
                end
            end
            TL_CLOSE: begin
                citya_d = prev_q;
                cityb_d = first_q;
                valid_d = 1'b1;
                state_d = TL_DRAIN;
            end
            TL_DRAIN: begin
                if (rcv_d >= n_q) begin
                    total_d = acc_d;
                    done_d  = 1'b1;
                    state_d = TL_FIN;
                end
            end
            TL_FIN: begin
                state_d = TL_IDLE;
            end
            default: begin
                state_d = TL_IDLE;
            end
        endcase

        busy_d = state_d inside {TL_PRIME, TL_STREAM, TL_CLOSE, TL_DRAIN};
    end

endmodule

// File: tb/tb_tour_length.sv
// Scoreboard bench for tour_length: city RAM and variable-latency distance
// models, expected pairs/totals queued at start and checked on output.
module tb_tour_length;
    import tsp_pkg::*;

    localparam int unsigned NMAX = 64;
    localparam int unsigned CW   = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW:0]   num_cities = '0;
    logic          city_rd_en;
    logic [CW-1:0] city_addr;
    logic [63:0]   city_data = '0;
    logic [63:0]   dist_citya;
    logic [63:0]   dist_cityb;
    logic          dist_valid;
    logic          dist_res_valid;
    logic [31:0]   dist_res;
    logic          busy;
    logic          done;
    logic [31:0]   total_len;

    logic          model_valid = 1'b0;
    logic [31:0]   model_res = '0;
    logic          stray_valid = 1'b0;

    assign dist_res_valid = model_valid | stray_valid;
    assign dist_res       = model_valid ? model_res : 32'd99;

    tour_length dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .num_cities     (num_cities),
        .city_rd_en     (city_rd_en),
        .city_addr      (city_addr),
        .city_data      (city_data),
        .dist_citya     (dist_citya),
        .dist_cityb     (dist_cityb),
        .dist_valid     (dist_valid),
        .dist_res_valid (dist_res_valid),
        .dist_res       (dist_res),
        .busy           (busy),
        .done           (done),
        .total_len      (total_len)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          errs = 0;
    int          checks = 0;
    logic [63:0] mem [NMAX];
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          last_rdy = 0;
    int          rdy_q [$];
    logic [31:0] val_q [$];
    logic [63:0] exp_a_q [$];
    logic [63:0] exp_b_q [$];
    int          exp_cyc_q [$];
    logic [31:0] exp_tot_q [$];
    int          exp_done_q [$];
    int          done_seen = 0;
    logic [31:0] last_total = '0;
    logic        done_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] isqrt(input logic [63:0] v);
        logic [63:0] r;
        logic [63:0] t;
        r = '0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= v) r = t;
        end
        return r[31:0];
    endfunction

    function automatic logic [31:0] edge_len(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] dx;
        logic [63:0] dy;
        dx = (a[31:0] > b[31:0]) ? 64'(a[31:0] - b[31:0]) : 64'(b[31:0] - a[31:0]);
        dy = (a[63:32] > b[63:32]) ? 64'(a[63:32] - b[63:32]) : 64'(b[63:32] - a[63:32]);
        return isqrt(dx * dx + dy * dy);
    endfunction

    // City RAM (one-cycle read) and in-order distance unit with variable latency.
    always @(posedge clk) begin
        int r;
        cyc = cyc + 1;
        if (city_rd_en) city_data <= mem[city_addr];
        if (!rst_n) begin
            rdy_q.delete();
            val_q.delete();
            model_valid <= 1'b0;
        end else begin
            if (dist_valid) begin
                r = cyc - 1 + int'($urandom_range(lat_hi, lat_lo));
                if (r <= last_rdy) r = last_rdy + 1;
                last_rdy = r;
                rdy_q.push_back(r);
                val_q.push_back(edge_len(dist_citya, dist_cityb));
            end
            if (rdy_q.size() > 0 && rdy_q[0] == cyc) begin
                model_valid <= 1'b1;
                model_res   <= val_q.pop_front();
                void'(rdy_q.pop_front());
            end else begin
                model_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int ec;
        if (done_prev) check("busy_after_done", 64'(busy), 64'd0);
        done_prev = done;
        if (dist_valid) begin
            if (exp_a_q.size() == 0) begin
                check("spurious_strobe", 64'(dist_valid), 64'd0);
            end else begin
                check("citya", dist_citya, exp_a_q.pop_front());
                check("cityb", dist_cityb, exp_b_q.pop_front());
                check("strobe_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
            end
        end
        if (done) begin
            done_seen++;
            last_total = total_len;
            if (exp_tot_q.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                check("total_len", 64'(total_len), 64'(exp_tot_q.pop_front()));
                ec = exp_done_q.pop_front();
                if (ec >= 0) check("done_cycle", 64'(cyc), 64'(ec));
            end
        end
    end

    // lat = 0 selects random latency 1..8 and skips the done-cycle check.
    task automatic start_tour(input int n_req, input int lat, output int s);
        int          n;
        int          k;
        logic [31:0] tot;
        n = (n_req > int'(NMAX)) ? int'(NMAX) : n_req;
        lat_lo = (lat == 0) ? 1 : lat;
        lat_hi = (lat == 0) ? 8 : lat;
        @(negedge clk);
        #1;
        s = cyc;
        tot = '0;
        if (n >= 2) begin
            for (int j = 1; j <= n; j++) begin
                k = j % n;
                exp_a_q.push_back(mem[j-1]);
                exp_b_q.push_back(mem[k]);
                exp_cyc_q.push_back(s + j + 3);
                tot = tot + edge_len(mem[j-1], mem[k]);
            end
        end
        exp_tot_q.push_back(tot);
        exp_done_q.push_back((n < 2) ? s + 2 : ((lat > 0) ? s + n + 4 + lat : -1));
        num_cities = (CW+1)'(n_req);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int k;
        d0 = done_seen;
        k = 0;
        while (done_seen == d0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("done_count", 64'(done_seen), 64'(d0 + 1));
    endtask

    task automatic load_square();
        mem[0] = city_pack(32'd0, 32'd0);
        mem[1] = city_pack(32'd3, 32'd0);
        mem[2] = city_pack(32'd3, 32'd4);
        mem[3] = city_pack(32'd0, 32'd4);
    endtask

    initial begin
        int s;
        int d0;
        for (int i = 0; i < int'(NMAX); i++) mem[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_rd_en", 64'(city_rd_en), 64'd0);
        check("rst_addr", 64'(city_addr), 64'd0);
        check("rst_valid", 64'(dist_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_total", 64'(total_len), 64'd0);
        check("rst_citya", dist_citya, 64'd0);
        check("rst_cityb", dist_cityb, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        load_square();
        start_tour(4, 1, s);
        wait_done(40);
        check("square_total", 64'(last_total), 64'd14);

        mem[0] = city_pack(32'd0, 32'd0);
        mem[1] = city_pack(32'd3, 32'd0);
        mem[2] = city_pack(32'd0, 32'd4);
        start_tour(3, 3, s);
        wait_done(40);
        check("triangle_total", 64'(last_total), 64'd12);

        mem[0] = city_pack(32'd0, 32'd0);
        mem[1] = city_pack(32'd0, 32'd5);
        start_tour(2, 2, s);
        wait_done(40);
        check("pair_total", 64'(last_total), 64'd10);

        start_tour(1, 1, s);
        wait_done(20);
        check("n1_total", 64'(last_total), 64'd0);
        start_tour(0, 1, s);
        wait_done(20);
        check("n0_total", 64'(last_total), 64'd0);

        // Start while busy and start in the done cycle are both ignored.
        load_square();
        start_tour(4, 2, s);
        repeat (2) @(negedge clk);
        num_cities = 7'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(40);
        num_cities = 7'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d0 = done_seen;
        stray_valid = 1'b1;
        repeat (3) @(negedge clk);
        stray_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("extra_done", 64'(done_seen), 64'(d0));
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_total", 64'(total_len), 64'd14);

        // Reset in the middle of a run: no done, outputs cleared.
        start_tour(4, 1, s);
        while (cyc < s + 5) @(negedge clk);
        d0 = done_seen;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_valid", 64'(dist_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_rd_en", 64'(city_rd_en), 64'd0);
        check("midrst_total", 64'(total_len), 64'd0);
        exp_a_q.delete();
        exp_b_q.delete();
        exp_cyc_q.delete();
        exp_tot_q.delete();
        exp_done_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_done", 64'(done_seen), 64'(d0));
        start_tour(4, 1, s);
        wait_done(40);
        check("after_rst_total", 64'(last_total), 64'd14);

        // Full-size random tour with variable distance latency, then a clamped size.
        for (int i = 0; i < int'(NMAX); i++)
            mem[i] = city_pack(32'($urandom_range(40000, 0)), 32'($urandom_range(40000, 0)));
        start_tour(64, 0, s);
        wait_done(400);
        start_tour(100, 0, s);
        wait_done(400);
        check("clamp_busy", 64'(busy), 64'd0);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
